// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the data-memory request arbiter.
// Width macros fall back to 32 bits when no project-wide definition is present.
`ifndef D_MEMORY_ADDR_WIDTH
`define D_MEMORY_ADDR_WIDTH 32
`endif
`ifndef REG_VAL_WIDTH
`define REG_VAL_WIDTH 32
`endif

package mem_arb_pkg;

  typedef enum logic {
    MEM_LOAD  = 1'b0,
    MEM_STORE = 1'b1
  } memory_op_t;

  localparam logic ERR_SPURIOUS_SET = 1'b1;

  // A single channel still needs a 1-bit index signal.
  function automatic int ch_idx_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/mem_id_fifo.sv
// Synchronous FIFO with show-ahead head output and occupancy count.
// A push while full is accepted only when a pop happens in the same cycle.
module mem_id_fifo #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = do_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    if (do_push && !do_pop) count_d = count_q + 1'b1;
    if (do_pop && !do_push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/mem_req_arbiter.sv
// Round-robin front end merging NUM_CH requesters onto one memory port,
// routing in-order acks back to the issuing channel via an ID FIFO.
module mem_req_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_CH          = 2,
  parameter int MAX_OUTSTANDING = 4,
  parameter int ADDR_W          = `D_MEMORY_ADDR_WIDTH,
  parameter int DATA_W          = `REG_VAL_WIDTH
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NUM_CH-1:0] ch_req_valid,
  input  memory_op_t        ch_req_op      [NUM_CH],
  input  logic [ADDR_W-1:0] ch_req_address [NUM_CH],
  input  logic [DATA_W-1:0] ch_req_data    [NUM_CH],
  output logic [NUM_CH-1:0] ch_req_ready,
  output logic [NUM_CH-1:0] ch_ack,
  output logic [DATA_W-1:0] ch_data_return,
  input  logic              memory_ready,
  input  logic              memory_ack,
  input  logic [DATA_W-1:0] memory_data_return,
  output logic              memory_req_valid,
  output memory_op_t        memory_req_op,
  output logic [ADDR_W-1:0] memory_req_address,
  output logic [DATA_W-1:0] memory_req_data,
  output logic              err_spurious_ack
);

  localparam int CW    = ch_idx_w(NUM_CH);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;

  logic              req_valid_q, req_valid_d;
  memory_op_t        req_op_q, req_op_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic [DATA_W-1:0] req_data_q, req_data_d;
  logic [NUM_CH-1:0] ch_ack_q, ch_ack_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              err_q, err_d;
  logic [CW-1:0]     rr_ptr_q, rr_ptr_d;

  logic [CW:0]       cand_sum, next_sum;
  logic [CW-1:0]     grant_idx;
  logic              found, free, room, issue, ack_valid;
  logic [CNT_W-1:0]  occ_next;
  logic [CW-1:0]     fifo_head;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_full, fifo_empty, fifo_push;

  assign ack_valid = memory_ack && !fifo_empty;
  assign occ_next  = fifo_count - CNT_W'(ack_valid);
  assign free      = !req_valid_q || memory_ready;
  assign room      = (occ_next < CNT_W'(MAX_OUTSTANDING));
  // Grants are suppressed while reset is held so every output reads 0.
  assign issue     = reset_n && free && room && found;
  assign fifo_push = issue && (!fifo_full || ack_valid);

  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    cand_sum  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cand_sum = {1'b0, rr_ptr_q} + (CW+1)'(i);
      if (cand_sum >= (CW+1)'(NUM_CH)) cand_sum = cand_sum - (CW+1)'(NUM_CH);
      if (!found && ch_req_valid[cand_sum[CW-1:0]]) begin
        found     = 1'b1;
        grant_idx = cand_sum[CW-1:0];
      end
    end
  end

  always_comb begin
    next_sum = {1'b0, grant_idx} + 1'b1;
    if (next_sum >= (CW+1)'(NUM_CH)) next_sum = '0;
    rr_ptr_d     = issue ? next_sum[CW-1:0] : rr_ptr_q;
    ch_req_ready = issue ? (NUM_CH'(1) << grant_idx) : '0;

    req_valid_d = req_valid_q;
    req_op_d    = req_op_q;
    req_addr_d  = req_addr_q;
    req_data_d  = req_data_q;
    if (free) begin
      req_valid_d = issue;
      if (issue) begin
        req_op_d   = ch_req_op[grant_idx];
        req_addr_d = ch_req_address[grant_idx];
        req_data_d = ch_req_data[grant_idx];
      end
    end

    ch_ack_d   = ack_valid ? (NUM_CH'(1) << fifo_head) : '0;
    rsp_data_d = ack_valid ? memory_data_return : rsp_data_q;
    err_d      = err_q;
    if (memory_ack && fifo_empty) err_d = ERR_SPURIOUS_SET;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_valid_q <= 1'b0;
      req_op_q    <= MEM_LOAD;
      req_addr_q  <= '0;
      req_data_q  <= '0;
      ch_ack_q    <= '0;
      rsp_data_q  <= '0;
      err_q       <= 1'b0;
      rr_ptr_q    <= '0;
    end else begin
      req_valid_q <= req_valid_d;
      req_op_q    <= req_op_d;
      req_addr_q  <= req_addr_d;
      req_data_q  <= req_data_d;
      ch_ack_q    <= ch_ack_d;
      rsp_data_q  <= rsp_data_d;
      err_q       <= err_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  mem_id_fifo #(
    .WIDTH(CW),
    .DEPTH(MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (fifo_push),
    .push_data(grant_idx),
    .pop      (ack_valid),
    .head     (fifo_head),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign memory_req_valid   = req_valid_q;
  assign memory_req_op      = req_op_q;
  assign memory_req_address = req_addr_q;
  assign memory_req_data    = req_data_q;
  assign ch_ack             = ch_ack_q;
  assign ch_data_return     = rsp_data_q;
  assign err_spurious_ack   = err_q;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter: 3 channels, 4 outstanding.
// Inputs change on the falling edge; outputs are sampled 1ns later.
module tb_mem_req_arbiter;
  import mem_arb_pkg::*;

  localparam int NCH  = 3;
  localparam int MAXO = 4;
  localparam int AW   = 32;
  localparam int DW   = 32;

  logic           clk = 1'b0;
  logic           reset_n = 1'b1;
  logic [NCH-1:0] ch_req_valid;
  memory_op_t     ch_req_op      [NCH];
  logic [AW-1:0]  ch_req_address [NCH];
  logic [DW-1:0]  ch_req_data    [NCH];
  logic [NCH-1:0] ch_req_ready;
  logic [NCH-1:0] ch_ack;
  logic [DW-1:0]  ch_data_return;
  logic           memory_ready;
  logic           memory_ack;
  logic [DW-1:0]  memory_data_return;
  logic           memory_req_valid;
  memory_op_t     memory_req_op;
  logic [AW-1:0]  memory_req_address;
  logic [DW-1:0]  memory_req_data;
  logic           err_spurious_ack;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [NCH-1:0] rr_exp    [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
  logic [AW-1:0]  rr_addr   [4] = '{32'h100, 32'h200, 32'h300, 32'h100};
  logic [NCH-1:0] route_pat [4] = '{3'b010, 3'b001, 3'b010, 3'b001};
  logic [DW-1:0]  route_dat [4] = '{32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003, 32'hDDDD_0004};

  always #5 clk = ~clk;

  mem_req_arbiter #(
    .NUM_CH(NCH),
    .MAX_OUTSTANDING(MAXO),
    .ADDR_W(AW),
    .DATA_W(DW)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .ch_req_valid      (ch_req_valid),
    .ch_req_op         (ch_req_op),
    .ch_req_address    (ch_req_address),
    .ch_req_data       (ch_req_data),
    .ch_req_ready      (ch_req_ready),
    .ch_ack            (ch_ack),
    .ch_data_return    (ch_data_return),
    .memory_ready      (memory_ready),
    .memory_ack        (memory_ack),
    .memory_data_return(memory_data_return),
    .memory_req_valid  (memory_req_valid),
    .memory_req_op     (memory_req_op),
    .memory_req_address(memory_req_address),
    .memory_req_data   (memory_req_data),
    .err_spurious_ack  (err_spurious_ack)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s = 0x%0h", tag, got);
    end
  endtask

  task automatic idle();
    ch_req_valid = '0;
    for (int i = 0; i < NCH; i++) begin
      ch_req_op[i]      = MEM_LOAD;
      ch_req_address[i] = 32'h100 * (i + 1);
      ch_req_data[i]    = 32'hD000 + i;
    end
    memory_ready       = 1'b1;
    memory_ack         = 1'b0;
    memory_data_return = '0;
  endtask

  task automatic next();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle();
    reset_n = 1'b0;
    next();
    reset_n = 1'b1;
  endtask

  initial begin
    idle();
    #1 reset_n = 1'b0;
    #1;
    check("reset req_valid", memory_req_valid, 1'b0);
    check("reset ch_ack", ch_ack, 3'b000);
    check("reset err", err_spurious_ack, 1'b0);
    check("reset ready", ch_req_ready, 3'b000);
    check("reset data_return", ch_data_return, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    // Single load
    ch_req_address[0] = 32'h10;
    ch_req_valid = 3'b001;
    #1;
    check("load grant", ch_req_ready, 3'b001);
    check("load no req yet", memory_req_valid, 1'b0);
    next();
    ch_req_valid = '0;
    #1;
    check("load req_valid", memory_req_valid, 1'b1);
    check("load req_addr", memory_req_address, 32'h10);
    check("load req_op", memory_req_op, MEM_LOAD);
    next();
    memory_ack = 1'b1;
    memory_data_return = 32'hDEAD;
    #1;
    check("load req drained", memory_req_valid, 1'b0);
    check("load no early ack", ch_ack, 3'b000);
    next();
    memory_ack = 1'b0;
    #1;
    check("load ch_ack", ch_ack, 3'b001);
    check("load data", ch_data_return, 32'hDEAD);
    next();
    #1;
    check("load ack pulse", ch_ack, 3'b000);

    // Round-robin fairness until full
    do_reset();
    ch_req_valid = 3'b111;
    for (int k = 0; k < 4; k++) begin
      #1;
      check($sformatf("rr grant %0d", k), ch_req_ready, rr_exp[k]);
      if (k > 0) check($sformatf("rr addr %0d", k - 1), memory_req_address, rr_addr[k - 1]);
      next();
    end
    #1;
    check("rr full stall", ch_req_ready, 3'b000);
    check("rr last addr", memory_req_address, 32'h100);
    next();
    #1;
    check("full REQ empties", memory_req_valid, 1'b0);
    check("full still stalled", ch_req_ready, 3'b000);

    // Full boundary: ack and ch0 request in the same cycle
    ch_req_valid = 3'b001;
    memory_ack = 1'b1;
    memory_data_return = 32'h1111;
    #1;
    check("full ack+grant", ch_req_ready, 3'b001);
    next();
    memory_ack = 1'b0;
    #1;
    check("full ch_ack", ch_ack, 3'b001);
    check("full ack data", ch_data_return, 32'h1111);
    check("full req reloaded", memory_req_valid, 1'b1);
    check("occ held at 4", ch_req_ready, 3'b000);

    // Response routing
    do_reset();
    for (int k = 0; k < 4; k++) begin
      ch_req_valid = route_pat[k];
      #1;
      check($sformatf("route grant %0d", k), ch_req_ready, route_pat[k]);
      next();
    end
    ch_req_valid = '0;
    for (int k = 0; k < 4; k++) begin
      memory_ack = 1'b1;
      memory_data_return = route_dat[k];
      #1;
      if (k > 0) begin
        check($sformatf("route ack %0d", k - 1), ch_ack, route_pat[k - 1]);
        check($sformatf("route data %0d", k - 1), ch_data_return, route_dat[k - 1]);
      end
      next();
    end
    memory_ack = 1'b0;
    #1;
    check("route ack 3", ch_ack, route_pat[3]);
    check("route data 3", ch_data_return, route_dat[3]);
    check("route no err", err_spurious_ack, 1'b0);

    // Spurious ack
    next();
    memory_ack = 1'b1;
    next();
    memory_ack = 1'b0;
    #1;
    check("spurious no ch_ack", ch_ack, 3'b000);
    check("spurious err set", err_spurious_ack, 1'b1);
    next();
    #1;
    check("spurious err sticky", err_spurious_ack, 1'b1);

    // Asynchronous reset with two requests in flight
    ch_req_valid = 3'b001;
    next();
    ch_req_valid = 3'b010;
    next();
    ch_req_valid = '0;
    #1;
    check("inflight req_valid", memory_req_valid, 1'b1);
    check("inflight req_addr", memory_req_address, 32'h200);
    #1 reset_n = 1'b0;
    #1;
    check("async rst req_valid", memory_req_valid, 1'b0);
    check("async rst req_addr", memory_req_address, 32'h0);
    check("async rst req_data", memory_req_data, 32'h0);
    check("async rst err", err_spurious_ack, 1'b0);
    check("async rst data_return", ch_data_return, 32'h0);
    check("async rst ch_ack", ch_ack, 3'b000);
    next();
    reset_n = 1'b1;
    memory_ack = 1'b1;
    next();
    memory_ack = 1'b0;
    #1;
    check("post-rst ack ignored", ch_ack, 3'b000);
    check("post-rst ack spurious", err_spurious_ack, 1'b1);

    // Back-pressure
    do_reset();
    memory_ready = 1'b0;
    ch_req_valid = 3'b100;
    ch_req_op[2] = MEM_STORE;
    ch_req_data[2] = 32'hBEEF;
    #1;
    check("bp first grant", ch_req_ready, 3'b100);
    next();
    ch_req_valid = 3'b001;
    ch_req_op[2] = MEM_LOAD;
    for (int k = 0; k < 5; k++) begin
      #1;
      check($sformatf("bp hold %0d", k),
            {memory_req_valid, memory_req_op, memory_req_address[15:0], memory_req_data[15:0]},
            {1'b1, MEM_STORE, 16'h0300, 16'hBEEF});
      check($sformatf("bp no grant %0d", k), ch_req_ready, 3'b000);
      next();
    end
    memory_ready = 1'b1;
    #1;
    check("bp accept+grant", ch_req_ready, 3'b001);
    next();
    ch_req_valid = '0;
    #1;
    check("bp next req_addr", memory_req_address, 32'h100);
    check("bp next req_valid", memory_req_valid, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
